// File: rtl/cpc_romsel_ctrl.sv
// cpc_romsel_ctrl
//  Clocked ROM-select front end for the eight-ROM expansion board.
//  Snoops Z80 I/O writes to &DFxx and holds the selected upper-ROM number.
//  From that number it drives ROMDIS, the four socket chip selects and
//  socket A14. Optionally it runs the timed EEPROM write cycle used for
//  in-system programming.
//
//  Optional feature macro: ROM_PROGRAM_EN
//    defined   -> write FSM (IDLE/PULSE/WAIT) drives ROM_WE_B and BUSY
//    undefined -> ROM_WE_B tied 1, BUSY tied 0 (same port list)
//
//  Ports
//    CLK        in   board clock, all state on rising edge
//    RESET      in   synchronous reset, active high
//    A[2:0]     in   bus address A[15:13]
//    D[7:0]     in   bus data
//    IOREQ_B    in   Z80 IORQ, active low
//    MREQ_B     in   Z80 MREQ, active low
//    WR_B       in   Z80 WR, active low
//    SLOT_MASK  in   per-slot populated mask (bit n = ROM n of bank)
//    WPROT      in   1 = block EEPROM writes
//    ROMDIS     out  board claims current upper-ROM selection
//    ROMCS_B    out  socket chip selects, active low (socket k = ROMs 2k,2k+1)
//    ROM_A14    out  socket A14 = romsel[0]
//    ROM_WE_B   out  EEPROM write enable, active low
//    BUSY       out  EEPROM write cycle in progress
//    ROMSEL     out  last value written to &DFxx
module cpc_romsel_ctrl #(
    parameter int BANK          = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int WE_PULSE_CLKS = 4,
    parameter int TWC_CLKS      = 160000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] A,
    input  logic [7:0] D,
    input  logic       IOREQ_B,
    input  logic       MREQ_B,
    input  logic       WR_B,
    input  logic [7:0] SLOT_MASK,
    input  logic       WPROT,
    output logic       ROMDIS,
    output logic [3:0] ROMCS_B,
    output logic       ROM_A14,
    output logic       ROM_WE_B,
    output logic       BUSY,
    output logic [7:0] ROMSEL
);

    localparam int          SYNC_W    = 14;
    // Bus idle: strobes high, address/data don't-care (cleared).
    localparam logic [13:0] SYNC_IDLE = {3'b000, 8'h00, 3'b111};
    localparam logic        BANK_BIT  = 1'(BANK);

    logic [SYNC_W-1:0] sync_r [SYNC_STAGES];
    logic [2:0]        a_s;
    logic [7:0]        d_s;
    logic              ioreq_b_s;
    logic              mreq_b_s;
    logic              wr_b_s;
    logic              sel_stb_s;
    logic              sel_stb_r;
    logic [7:0]        romsel_r;
    logic              hit_s;
    logic [3:0]        cs_b_s;
    logic              freeze_s;
    logic              romdis_r;
    logic [3:0]        romcs_b_r;
    logic              rom_a14_r;

    // Synchronizer chain for every bus input.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= SYNC_IDLE;
            end
        end else begin
            sync_r[0] <= {A, D, IOREQ_B, MREQ_B, WR_B};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign a_s       = sync_r[SYNC_STAGES-1][13:11];
    assign d_s       = sync_r[SYNC_STAGES-1][10:3];
    assign ioreq_b_s = sync_r[SYNC_STAGES-1][2];
    assign mreq_b_s  = sync_r[SYNC_STAGES-1][1];
    assign wr_b_s    = sync_r[SYNC_STAGES-1][0];

    // &DFxx decode only needs A13 low during an I/O write.
    assign sel_stb_s = ~ioreq_b_s & ~wr_b_s & ~a_s[0];

    // ROM-select register: loads once on the rising edge of the strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_stb_r <= 1'b0;
            romsel_r  <= 8'hFF;
        end else begin
            sel_stb_r <= sel_stb_s;
            if (sel_stb_s && !sel_stb_r) begin
                romsel_r <= d_s;
            end else begin
                romsel_r <= romsel_r;
            end
        end
    end

    // Board claims the ROM only if in range, in our bank and populated.
    always_comb begin
        hit_s = 1'b0;
        if ((romsel_r[7:4] == 4'h0) && (romsel_r[3] == BANK_BIT) &&
            SLOT_MASK[romsel_r[2:0]]) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // One socket per ROM pair; unclaimed numbers leave every socket idle.
    always_comb begin
        cs_b_s = 4'hF;
        if (hit_s) begin
            cs_b_s[romsel_r[2:1]] = 1'b0;
        end else begin
            cs_b_s = 4'hF;
        end
    end

    // Output register; held while an EEPROM write cycle is in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            romdis_r  <= 1'b0;
            romcs_b_r <= 4'hF;
            rom_a14_r <= 1'b1;
        end else if (!freeze_s) begin
            romdis_r  <= hit_s;
            romcs_b_r <= cs_b_s;
            rom_a14_r <= romsel_r[0];
        end else begin
            romdis_r  <= romdis_r;
            romcs_b_r <= romcs_b_r;
            rom_a14_r <= rom_a14_r;
        end
    end

    assign ROMDIS  = romdis_r;
    assign ROMCS_B = romcs_b_r;
    assign ROM_A14 = rom_a14_r;
    assign ROMSEL  = romsel_r;

`ifdef ROM_PROGRAM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } wr_state_t;

    localparam int CNT_MAX = (TWC_CLKS > WE_PULSE_CLKS) ? TWC_CLKS : WE_PULSE_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    wr_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             we_b_r;
    logic             busy_r;
    logic             wr_stb_s;
    logic             wr_stb_r;

    // Memory write into &C000-&FFFF targets the selected EEPROM.
    assign wr_stb_s = ~mreq_b_s & ~wr_b_s & (a_s[2:1] == 2'b11);
    assign freeze_s = (state_r != ST_IDLE);

    // EEPROM write FSM: WE pulse, then the device's internal write time.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            we_b_r   <= 1'b1;
            busy_r   <= 1'b0;
            wr_stb_r <= 1'b0;
        end else begin
            wr_stb_r <= wr_stb_s;
            case (state_r)
                ST_IDLE: begin
                    if (wr_stb_s && !wr_stb_r && hit_s && !WPROT) begin
                        state_r <= ST_PULSE;
                        cnt_r   <= '0;
                        we_b_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == CNT_W'(WE_PULSE_CLKS - 1)) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= '0;
                        we_b_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_W'(TWC_CLKS - 1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    we_b_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ROM_WE_B = we_b_r;
    assign BUSY     = busy_r;
`else
    logic unused_s;

    assign freeze_s = 1'b0;
    assign ROM_WE_B = 1'b1;
    assign BUSY     = 1'b0;
    assign unused_s = ^{WPROT, mreq_b_s, a_s[2:1], 32'(WE_PULSE_CLKS), 32'(TWC_CLKS)};
`endif

endmodule

// File: tb/tb_cpc_romsel_ctrl.sv
module tb_cpc_romsel_ctrl;

    localparam int SYNC = 2;
    localparam int WEP  = 4;
    localparam int TWC  = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a;
    logic [7:0] d;
    logic       ioreq_b, mreq_b, wr_b;
    logic [7:0] slot_mask;
    logic       wprot;

    logic       romdis0, a14_0, we_b0, busy0;
    logic [3:0] cs0;
    logic [7:0] sel0;
    logic       romdis1, a14_1, we_b1, busy1;
    logic [3:0] cs1;
    logic [7:0] sel1;

    int checks = 0;
    int errors = 0;

    cpc_romsel_ctrl #(.BANK(0), .SYNC_STAGES(SYNC), .WE_PULSE_CLKS(WEP), .TWC_CLKS(TWC)) u_dut0 (
        .CLK(clk), .RESET(rst), .A(a), .D(d), .IOREQ_B(ioreq_b), .MREQ_B(mreq_b),
        .WR_B(wr_b), .SLOT_MASK(slot_mask), .WPROT(wprot), .ROMDIS(romdis0),
        .ROMCS_B(cs0), .ROM_A14(a14_0), .ROM_WE_B(we_b0), .BUSY(busy0), .ROMSEL(sel0));

    cpc_romsel_ctrl #(.BANK(1), .SYNC_STAGES(SYNC), .WE_PULSE_CLKS(WEP), .TWC_CLKS(TWC)) u_dut1 (
        .CLK(clk), .RESET(rst), .A(a), .D(d), .IOREQ_B(ioreq_b), .MREQ_B(mreq_b),
        .WR_B(wr_b), .SLOT_MASK(slot_mask), .WPROT(wprot), .ROMDIS(romdis1),
        .ROMCS_B(cs1), .ROM_A14(a14_1), .ROM_WE_B(we_b1), .BUSY(busy1), .ROMSEL(sel1));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] mask;
        logic       romdis;
        logic [3:0] cs;
        logic       a14;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: outputs implied by a ROM number, bank and slot mask.
    function automatic logic [5:0] exp_out(input int sel, input int bank, input logic [7:0] mask);
        logic hit;
        logic [3:0] cs;
        hit = (sel < 16) && ((sel / 8) == bank) && mask[sel % 8];
        cs  = hit ? ~(4'b0001 << ((sel % 8) / 2)) : 4'hF;
        return {hit, cs, 1'(sel % 2)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        a = 3'b111; d = 8'h00; ioreq_b = 1'b1; mreq_b = 1'b1; wr_b = 1'b1;
    endtask

    task automatic out_df(input logic [7:0] val, input int hold);
        a = 3'b110; d = val; ioreq_b = 1'b0; wr_b = 1'b1; wr_b = 1'b0;
        tick(hold);
        bus_idle();
    endtask

    task automatic mem_wr_start();
        a = 3'b110; d = 8'h5A; ioreq_b = 1'b1; mreq_b = 1'b0; wr_b = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt, busy_cnt, bad, model_sel, found;
        logic [7:0] mask;

        vecs[0] = '{8'h05, 8'hFF, 1'b1, 4'b1011, 1'b1};
        vecs[1] = '{8'h0D, 8'hFF, 1'b0, 4'b1111, 1'b1};
        vecs[2] = '{8'h00, 8'hFE, 1'b0, 4'b1111, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 4'b1110, 1'b0};
        vecs[4] = '{8'h07, 8'hFF, 1'b1, 4'b0111, 1'b1};
        vecs[5] = '{8'h07, 8'h7F, 1'b0, 4'b1111, 1'b1};
        vecs[6] = '{8'h12, 8'hFF, 1'b0, 4'b1111, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 4'b1111, 1'b1};
        vecs[8] = '{8'h03, 8'h08, 1'b1, 4'b1101, 1'b1};
        vecs[9] = '{8'h02, 8'h08, 1'b0, 4'b1111, 1'b0};

        bus_idle();
        slot_mask = 8'hFF; wprot = 1'b0; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("rst_romsel", 32'(sel0), 32'hFF);
        check("rst_romdis", 32'(romdis0), 32'h0);
        check("rst_cs", 32'(cs0), 32'hF);
        check("rst_a14", 32'(a14_0), 32'h1);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_we", 32'(we_b0), 32'h1);

        // Exact latency: strobe asserted -> outputs on edge SYNC+2.
        a = 3'b110; d = 8'h05; ioreq_b = 1'b0; wr_b = 1'b0;
        tick(SYNC + 1);
        check("lat_early_romdis", 32'(romdis0), 32'h0);
        check("lat_romsel", 32'(sel0), 32'h05);
        tick(1);
        check("lat_romdis", 32'(romdis0), 32'h1);
        check("lat_cs", 32'(cs0), 32'b1011);
        check("lat_a14", 32'(a14_0), 32'h1);
        tick(3);
        bus_idle();
        tick(SYNC + 3);

        // Slot mask change takes effect on the next output update.
        slot_mask = 8'hDF;
        tick(1);
        check("mask_live_romdis", 32'(romdis0), 32'h0);
        slot_mask = 8'hFF;

        // Bank 1 claims &0D, bank 0 does not.
        out_df(8'h0D, 3);
        tick(SYNC + 3);
        check("b0_0d_romdis", 32'(romdis0), 32'h0);
        check("b0_0d_cs", 32'(cs0), 32'hF);
        check("b1_0d_romdis", 32'(romdis1), 32'h1);
        check("b1_0d_cs", 32'(cs1), 32'b1011);

        for (int i = 0; i < 10; i++) begin
            slot_mask = vecs[i].mask;
            out_df(vecs[i].d, 2);
            tick(SYNC + 3);
            check("tbl_romsel", 32'(sel0), 32'(vecs[i].d));
            check("tbl_romdis", 32'(romdis0), 32'(vecs[i].romdis));
            check("tbl_cs", 32'(cs0), 32'(vecs[i].cs));
            check("tbl_a14", 32'(a14_0), 32'(vecs[i].a14));
        end

        // Long strobe with data changing mid-strobe: only the first value loads.
        slot_mask = 8'hFE;
        a = 3'b110; d = 8'h00; ioreq_b = 1'b0; wr_b = 1'b0;
        tick(5);
        d = 8'h05;
        tick(5);
        bus_idle();
        tick(SYNC + 3);
        check("long_romsel", 32'(sel0), 32'h00);
        check("long_romdis", 32'(romdis0), 32'h0);
        check("long_cs", 32'(cs0), 32'hF);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            mask = 8'($urandom);
            slot_mask = mask;
            model_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                // Non-&DFxx I/O write (A13 high) and an I/O read at &DFxx.
                a = 3'b111; d = 8'($urandom); ioreq_b = 1'b0; wr_b = 1'b0;
                tick($urandom_range(1, 4));
                bus_idle();
                tick(SYNC + 2);
                a = 3'b110; d = 8'($urandom); ioreq_b = 1'b0; wr_b = 1'b1;
                tick($urandom_range(1, 4));
                bus_idle();
                tick(SYNC + 2);
            end
            out_df(8'(model_sel), $urandom_range(1, 6));
            tick(SYNC + 3);
            check("rnd_sel0", 32'(sel0), 32'(model_sel));
            check("rnd_out0", 32'({romdis0, cs0, a14_0}), 32'(exp_out(model_sel, 0, mask)));
            check("rnd_out1", 32'({romdis1, cs1, a14_1}), 32'(exp_out(model_sel, 1, mask)));
        end

        slot_mask = 8'hFF;
        out_df(8'h02, 3);
        tick(SYNC + 3);
        check("sel2_cs", 32'(cs0), 32'b1101);

`ifdef ROM_PROGRAM_EN
        // Write to &C123: one WE pulse, second write during WAIT ignored.
        we_cnt = 0; busy_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 0 || cyc == 100) mem_wr_start();
            if (cyc == 12 || cyc == 112) bus_idle();
            tick(1);
            if (we_b0 == 1'b0) we_cnt++;
            if (busy0 == 1'b1) busy_cnt++;
        end
        check("pgm_we_len", 32'(we_cnt), 32'(WEP));
        check("pgm_busy_len", 32'(busy_cnt), 32'(WEP + TWC));
        check("pgm_idle_busy", 32'(busy0), 32'h0);

        // Write protect blocks the cycle.
        wprot = 1'b1;
        we_cnt = 0; busy_cnt = 0;
        mem_wr_start();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 12) bus_idle();
            tick(1);
            if (we_b0 == 1'b0) we_cnt++;
            if (busy0 == 1'b1) busy_cnt++;
        end
        check("wprot_we", 32'(we_cnt), 32'h0);
        check("wprot_busy", 32'(busy_cnt), 32'h0);
        wprot = 1'b0;

        // &DFxx during WAIT: ROMSEL moves at once, outputs frozen until idle.
        mem_wr_start();
        tick(12);
        bus_idle();
        check("frz_busy", 32'(busy0), 32'h1);
        out_df(8'h07, 4);
        tick(SYNC + 3);
        check("frz_romsel", 32'(sel0), 32'h07);
        check("frz_cs", 32'(cs0), 32'b1101);
        check("frz_a14", 32'(a14_0), 32'h0);
        found = 0;
        for (int cyc = 0; cyc < 400 && found == 0; cyc++) begin
            tick(1);
            if (busy0 == 1'b0) found = 1;
        end
        check("frz_busy_falls", 32'(found), 32'h1);
        check("frz_cs_at_fall", 32'(cs0), 32'b1101);
        tick(1);
        check("frz_cs_after", 32'(cs0), 32'b0111);
        check("frz_a14_after", 32'(a14_0), 32'h1);

        // Reset in the middle of the WE pulse.
        mem_wr_start();
        found = 0;
        for (int cyc = 0; cyc < 10 && found == 0; cyc++) begin
            tick(1);
            if (we_b0 == 1'b0) found = 1;
        end
        check("mid_pulse_seen", 32'(found), 32'h1);
        bus_idle();
        rst = 1'b1;
        tick(1);
        check("mid_rst_we", 32'(we_b0), 32'h1);
        check("mid_rst_busy", 32'(busy0), 32'h0);
        check("mid_rst_romsel", 32'(sel0), 32'hFF);
        rst = 1'b0;
        tick(SYNC + 5);
        check("post_rst_busy", 32'(busy0), 32'h0);
        check("post_rst_we", 32'(we_b0), 32'h1);
`else
        // Without programming support the write-enable stays idle.
        bad = 0;
        mem_wr_start();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 12) bus_idle();
            tick(1);
            if (we_b0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("nopgm_idle", 32'(bad), 32'h0);
        check("nopgm_romsel", 32'(sel0), 32'h02);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
